// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the data memory.
interface mem_port_arbiter_if #(
    parameter int unsigned mem_add_width = 32,
    parameter int unsigned mem_width     = 32
);
    // CPU master (m0)
    logic                     m0_req;
    logic                     m0_wr;
    logic [mem_add_width-1:0] m0_add;
    logic [mem_width-1:0]     m0_wdata;
    logic                     m0_ack;
    logic                     m0_err;
    logic [mem_width-1:0]     m0_rdata;

    // Loader/debug master (m1)
    logic                     m1_req;
    logic                     m1_wr;
    logic                     m1_lock;
    logic [mem_add_width-1:0] m1_add;
    logic [mem_width-1:0]     m1_wdata;
    logic                     m1_ack;
    logic                     m1_err;
    logic [mem_width-1:0]     m1_rdata;

    // Data memory port
    logic                     mem_wr_en;
    logic [mem_add_width-1:0] mem_add;
    logic [mem_width-1:0]     mem_wdata;
    logic [mem_width-1:0]     mem_rdata;

    // CPU pipeline stall
    logic                     cpu_stall;

    // Arbiter view
    modport slave (
        input  m0_req, m0_wr, m0_add, m0_wdata,
        input  m1_req, m1_wr, m1_lock, m1_add, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_wr_en, mem_add, mem_wdata,
        output cpu_stall
    );

    // Requester / memory-side view
    modport master (
        output m0_req, m0_wr, m0_add, m0_wdata,
        output m1_req, m1_wr, m1_lock, m1_add, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_wr_en, mem_add, mem_wdata,
        input  cpu_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Each access runs IDLE -> SERVE -> RESP; round-robin with an optional
// bounded lock that lets m1 keep the port for a burst of accesses.
module mem_port_arbiter #(
    parameter int unsigned mem_add_width = 32,
    parameter int unsigned mem_width     = 32,
    parameter int unsigned mem_depth     = 256,
    parameter int unsigned lock_max      = 8
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned cnt_w = $clog2(lock_max + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     win_m1_q;
    logic                     last_m1_q;
    logic                     lock_hold_q;
    logic [cnt_w-1:0]         lock_cnt_q;
    logic                     wr_q;
    logic                     err_q;
    logic [mem_add_width-1:0] add_q;
    logic [mem_width-1:0]     wdata_q;
    logic                     wr_en_q;
    logic [mem_width-1:0]     rdata_q;
    logic                     ack0_q;
    logic                     ack1_q;
    logic                     err0_q;
    logic                     err1_q;

    logic                     any_req;
    logic                     grant_m1;
    logic                     sel_wr;
    logic                     sel_err;
    logic [mem_add_width-1:0] sel_add;
    logic [mem_width-1:0]     sel_wdata;
    logic [cnt_w-1:0]         lock_cnt_nxt;
    logic                     lock_hold_nxt;

    // Winner selection and request mux, evaluated for use in IDLE only
    always_comb begin
        any_req       = bus.m0_req | bus.m1_req;
        grant_m1      = 1'b0;
        lock_cnt_nxt  = '0;
        lock_hold_nxt = 1'b0;

        if (bus.m0_req && bus.m1_req) begin
            if (lock_hold_q && bus.m1_lock) begin
                // m1 keeps the port until the lock budget runs out
                grant_m1 = (lock_cnt_q < cnt_w'(lock_max));
            end else begin
                grant_m1 = ~last_m1_q;
            end
        end else begin
            grant_m1 = bus.m1_req;
        end

        if (grant_m1 && bus.m1_lock) begin
            lock_hold_nxt = 1'b1;
            lock_cnt_nxt  = (lock_cnt_q < cnt_w'(lock_max)) ? lock_cnt_q + cnt_w'(1) : lock_cnt_q;
        end

        sel_wr    = grant_m1 ? bus.m1_wr    : bus.m0_wr;
        sel_add   = grant_m1 ? bus.m1_add   : bus.m0_add;
        sel_wdata = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
        // Word index beyond the memory is an error; byte offset bits ignored
        sel_err   = 64'(sel_add[mem_add_width-1:2]) >= 64'(mem_depth);
    end

    // Access FSM with all state and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_m1_q    <= 1'b0;
            last_m1_q   <= 1'b1;
            lock_hold_q <= 1'b0;
            lock_cnt_q  <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            add_q       <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q     <= SERVE;
                        win_m1_q    <= grant_m1;
                        last_m1_q   <= grant_m1;
                        lock_hold_q <= lock_hold_nxt;
                        lock_cnt_q  <= lock_cnt_nxt;
                        wr_q        <= sel_wr;
                        err_q       <= sel_err;
                        add_q       <= sel_add;
                        wdata_q     <= sel_wdata;
                        wr_en_q     <= sel_wr & ~sel_err;
                    end
                end
                SERVE: begin
                    state_q <= RESP;
                    wr_en_q <= 1'b0;
                    rdata_q <= (err_q || wr_q) ? '0 : bus.mem_rdata;
                    ack0_q  <= ~win_m1_q;
                    ack1_q  <= win_m1_q;
                    err0_q  <= ~win_m1_q & err_q;
                    err1_q  <= win_m1_q & err_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err0_q  <= 1'b0;
                    err1_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe and acks are masked by reset so an aborted access
    // neither writes memory nor completes in the reset cycle
    assign bus.mem_wr_en = wr_en_q & rst;
    assign bus.m0_ack    = ack0_q & rst;
    assign bus.m1_ack    = ack1_q & rst;

    assign bus.mem_add   = add_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m0_err    = err0_q;
    assign bus.m1_err    = err1_q;
    assign bus.m0_rdata  = rdata_q;
    assign bus.m1_rdata  = rdata_q;

    // CPU is stalled while its request is outstanding
    assign bus.cpu_stall = bus.m0_req & ~bus.m0_ack;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter mem_add_width, default 32, meaning byte-address width.
REQ-002 SHALL have parameter mem_width, default 32, meaning data word width.
REQ-003 SHALL have parameter mem_depth, default 256, meaning number of words in the data memory.
REQ-004 SHALL have parameter lock_max, default 8, meaning the maximum number of consecutive locked m1 grants.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have ports m0_req, m0_wr, input, 1 each: CPU request and write select.
REQ-008 SHALL have ports m0_add (mem_add_width) and m0_wdata (mem_width), inputs: CPU address and write data.
REQ-009 SHALL have ports m0_ack (1), m0_err (1) and m0_rdata (mem_width), outputs: CPU completion, error and read data.
REQ-010 SHALL have ports m1_req, m1_wr, m1_lock, m1_add, m1_wdata, m1_ack, m1_err and m1_rdata for the loader/debug master, with widths and directions as m0 and m1_lock an input of width 1.
REQ-011 SHALL have ports mem_wr_en (1), mem_add (mem_add_width) and mem_wdata (mem_width), outputs to the data memory.
REQ-012 SHALL have port mem_rdata, input, mem_width, the combinational read data from memory.
REQ-013 SHALL have port cpu_stall, output, 1, high while an m0 request is pending and not yet acked.

Function
REQ-014 SHALL implement the FSM states IDLE, SERVE and RESP.
REQ-015 In IDLE with at least one req high, SHALL select a winner, latch its wr/add/wdata into internal registers, record the winner, and go to SERVE; with no req high, SHALL stay in IDLE.
REQ-016 In SERVE, SHALL drive mem_add and mem_wdata from the latched registers, assert mem_wr_en equal to the latched wr (suppressed on error), capture mem_rdata (or 0 on error/write) into the rdata register, and go to RESP.
REQ-017 In RESP, SHALL assert the winner's ack for exactly one cycle with rdata and err valid, and go to IDLE; the other master's ack SHALL stay 0.
REQ-018 Latency from req sampled in IDLE to ack SHALL be 2 cycles; one access SHALL complete per 3 cycles at most.
REQ-019 Outside SERVE, mem_wr_en SHALL be 0; mem_add and mem_wdata SHALL hold their latched values.
REQ-020 Requesters SHALL hold req, wr, add and wdata stable until ack; the arbiter SHALL sample them only in IDLE.
REQ-021 A req still high during the RESP cycle SHALL NOT be treated as a new request until the following IDLE.
REQ-022 Arbitration SHALL be round-robin: when both masters request, the one not granted last SHALL win; the last-grant register SHALL reset to m1 so m0 wins first.
REQ-023 If m1 was granted with m1_lock=1, the next arbitrations SHALL favour m1 over m0 while m1_lock and m1_req stay high.
REQ-024 A lock counter SHALL count consecutive locked m1 grants; at lock_max SHALL force one m0 grant if m0_req is high, then clear to 0.
REQ-025 The lock counter SHALL also clear on any m0 grant or on m1_lock=0 at arbitration.
REQ-026 Out-of-range addresses SHALL be flagged as errors: an address whose word index (add[mem_add_width-1:2]) is >= mem_depth SHALL NOT write memory, SHALL return rdata=0, and SHALL assert err with ack.
REQ-027 Address bits [1:0] SHALL be ignored; mem_add SHALL be passed through unmodified.
REQ-028 cpu_stall SHALL equal m0_req AND NOT m0_ack, combinationally.

Reset
REQ-029 With rst=0 at a rising edge, SHALL go to IDLE, clear the latched registers, rdata, lock counter and both acks/errs, and set last-grant=m1.
REQ-030 Reset asserted mid-access (SERVE or RESP) SHALL abort the access with no ack and no memory write in the reset cycle.
REQ-031 All registered outputs SHALL read 0 the cycle after reset.

Verification
REQ-032 m0 reads from add 0x10 with mem word 4=0xDEADBEEF -> mem_add=0x10 in cycle 1, m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 2, cpu_stall low in cycle 2.
REQ-033 m0 and m1 request in the same cycle after reset -> m0 acked first, then m1; the next simultaneous pair -> m0 again.
REQ-034 m1 writes 0x12345678 to 0x400 with mem_depth=256 -> mem_wr_en never high, m1_err=1, m1_rdata=0.
REQ-035 m1_lock=1 with continuous m1_req and m0_req -> exactly 8 m1 grants, then 1 m0 grant, then m1 resumes.
REQ-036 rst=0 during SERVE of an m0 write -> no memory write, no m0_ack, state IDLE, all outputs 0 the next cycle.
